pillar_ctrl: RTL and testbench
==============================

# pillar_ctrl

Generates the position of the scrolling pillar pair for the game's video path. It advances the pillar leftward once per video frame and respawns it at the right edge with a pseudo-random gap height. It also raises a one-cycle score pulse when the pillar passes the bird column. Its outputs feed the pillar sprite lookup stages directly: `pillar_up_x` → right-edge column, `pillar_y` → top row of the lower pillar sprite.

## Interface
- `X_START`, 691: right-edge column at spawn; sprite fully off-screen right (640 + 51).
- `SPEED`, 2: pixels moved left per frame tick.
- `Y_MIN`, 160: minimum `pillar_y`.
- `Y_INIT`, 288: `pillar_y` after reset or restart.
- `GAP`, 120: vertical gap height in rows.
- `BIRD_X`, 200: bird column used for scoring; must satisfy `BIRD_X` ≥ `SPEED`.
- `LFSR_SEED`, 16'hACE1: nonzero LFSR reset value.

Ports:
- `clk`  in  1: system clock; all state updates on the rising edge.
- `rst_n`  in  1: asynchronous active-low reset.
- `frame_tick`  in  1: one-cycle pulse per frame, at vertical blank.
- `start`  in  1: level; begins or restarts a run.
- `game_over`  in  1: level; freezes motion.
- `pillar_up_x`  out  10: right-edge column of the pillar sprite, registered.
- `pillar_y`  out  9: top row of the lower pillar (bottom of gap), registered.
- `gap_top`  out  9: `pillar_y` − `GAP`, i.e. the bottom row of the upper pillar. Combinational from the register.
- `pillar_active`  out  1: high in RUN.
- `score_pulse`  out  1: one-cycle pulse when the pillar passes `BIRD_X`, registered.

## Operation
- FSM states: IDLE, RUN, STOP. Reset state is IDLE.
  - IDLE: `start` → RUN.
  - RUN: `game_over` → STOP. If `start` and `game_over` are high together, `game_over` wins.
  - STOP: `start` (with `game_over` low) → RUN. On this transition, `pillar_up_x` ← `X_START` and `pillar_y` ← `Y_INIT`.
  - IDLE and STOP ignore `frame_tick`; positions hold.
- In RUN, on a cycle with `frame_tick` high:
  - If `pillar_up_x` < `SPEED`, respawn: `pillar_up_x` ← `X_START` and `pillar_y` ← `Y_MIN` + {1'b0, `lfsr[7:0]`}, giving a range of 160..415.
  - Otherwise, `pillar_up_x` ← `pillar_up_x` − `SPEED`.
  - `score_pulse` ← 1 iff the old `pillar_up_x` ≥ `BIRD_X` and the new value < `BIRD_X`. It is never set on the respawn cycle.
- LFSR: 16-bit Fibonacci, taps 16, 14, 13, 11 (maximal length). It advances every clock in every state, so the gap sequence depends on player timing. It never reaches zero.
- Width rules:
  - Subtraction is unsigned 10-bit. The `SPEED` guard prevents underflow.
  - The `pillar_y` sum fits in 9 bits (max 415).
  - `gap_top` ≥ 40 is guaranteed by `Y_MIN` ≥ `GAP`.
- Reset values: state IDLE, `pillar_up_x` = 691, `pillar_y` = 288, `gap_top` = 168, `pillar_active` = 0, `score_pulse` = 0, lfsr = 16'hACE1.
- Asserting `rst_n` low mid-run returns everything to the reset values immediately, with no clock required.

## Timing
- `frame_tick` sampled at edge N → new position is visible after edge N (one-cycle latency). `score_pulse` is high for exactly the cycle after edge N.
- `start` sampled at edge N → `pillar_active` high after edge N. A `frame_tick` at edge N is ignored, because the state is not yet RUN.
- `game_over` sampled at edge N → a tick at edge N is ignored and the position freezes.
- Outputs change only on `clk` edges or on reset, so downstream ROM address logic sees values stable for the whole frame.

## Structure
- Shared package `pillar_pkg` holds:
  - state encoding: IDLE = 2'd0, RUN = 2'd1, STOP = 2'd2;
  - the screen constants H_ACTIVE = 640, V_ACTIVE = 480, SPRITE_W = 52;
  - the default parameter values above.
- Sub-module `lfsr16`, with ports `clk`, `rst_n`, `seed`, and `q[15:0]`. It is reused by any later random-spawn logic.

## Test plan
- Reset: with `rst_n` low and `clk` stopped, `pillar_up_x` = 691, `pillar_y` = 288, `gap_top` = 168, `pillar_active` = 0, `score_pulse` = 0.
- Motion: `start`, then 10 `frame_tick` pulses → `pillar_up_x` = 671, `pillar_y` unchanged at 288. Ticks sent in IDLE before `start` leave 691.
- Score: run 245 ticks (691 → 201), then tick once more → 199 and `score_pulse` is high for exactly one cycle. No pulse occurs on any other tick.
- Respawn: drive the pillar to `pillar_up_x` = 1, then tick → 691, `pillar_y` = 160 + `lfsr[7:0]`, matching the reference LFSR model, and no `score_pulse`.
- Freeze/restart:
  - `game_over` together with `frame_tick` → position unchanged and `pillar_active` = 0.
  - `start` in STOP → 691/288 and RUN.
  - `start` + `game_over` together in RUN → STOP.
- Async reset mid-run at `pillar_up_x` = 431 → outputs return to the reset values without a clock edge, and the FSM is in IDLE afterward.

Source files
------------

// File: rtl/pillar_pkg.sv
// Shared types and constants for the scrolling pillar pair: FSM encoding,
// screen geometry and default tuning values for pillar_ctrl.
package pillar_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    STOP = 2'd2
  } state_t;

  localparam int H_ACTIVE = 640;
  localparam int V_ACTIVE = 480;
  localparam int SPRITE_W = 52;

  // Right edge of a sprite whose leftmost column sits just past the screen.
  localparam logic [9:0]  X_START_DEF   = 10'(H_ACTIVE + SPRITE_W - 1);
  localparam logic [9:0]  SPEED_DEF     = 10'd2;
  localparam logic [8:0]  Y_MIN_DEF     = 9'd160;
  localparam logic [8:0]  Y_INIT_DEF    = 9'd288;
  localparam logic [8:0]  GAP_DEF       = 9'd120;
  localparam logic [9:0]  BIRD_X_DEF    = 10'd200;
  localparam logic [15:0] LFSR_SEED_DEF = 16'hACE1;

  // Lowest spawn row plus the full 8-bit random span must stay on screen.
  localparam int Y_SPAWN_MAX = int'(Y_MIN_DEF) + 255;
  localparam bit Y_FITS      = (Y_SPAWN_MAX < V_ACTIVE);

  // Feedback bit for the 16-bit Fibonacci LFSR, taps 16, 14, 13, 11.
  function automatic logic lfsr_fb(input logic [15:0] v);
    return v[15] ^ v[13] ^ v[12] ^ v[10];
  endfunction

endpackage

// File: rtl/pillar_ctrl_lfsr16.sv
// Free-running 16-bit maximal-length LFSR; loads seed on reset and shifts
// every clock. A nonzero seed keeps it out of the all-zero lock-up state.
module lfsr16
  import pillar_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] seed,
  output logic [15:0] q
);

  logic [15:0] q_reg;
  logic [15:0] q_next;

  assign q_next[0] = lfsr_fb(q_reg);

  generate
    for (genvar gi = 1; gi < 16; gi++) begin : g_shift
      assign q_next[gi] = q_reg[gi-1];
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_reg <= seed;
    end else begin
      q_reg <= q_next;
    end
  end

  assign q = q_reg;

endmodule

// File: rtl/pillar_ctrl.sv
// Scrolling pillar position generator: moves the pillar left once per frame,
// respawns it at the right edge with a random gap row, and pulses on scoring.
module pillar_ctrl
  import pillar_pkg::*;
#(
  parameter logic [9:0]  X_START   = X_START_DEF,
  parameter logic [9:0]  SPEED     = SPEED_DEF,
  parameter logic [8:0]  Y_MIN     = Y_MIN_DEF,
  parameter logic [8:0]  Y_INIT    = Y_INIT_DEF,
  parameter logic [8:0]  GAP       = GAP_DEF,
  parameter logic [9:0]  BIRD_X    = BIRD_X_DEF,
  parameter logic [15:0] LFSR_SEED = LFSR_SEED_DEF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       frame_tick,
  input  logic       start,
  input  logic       game_over,
  output logic [9:0] pillar_up_x,
  output logic [8:0] pillar_y,
  output logic [8:0] gap_top,
  output logic       pillar_active,
  output logic       score_pulse
);

  state_t      state_reg, state_next;
  logic [9:0]  x_reg, x_next;
  logic [8:0]  y_reg, y_next;
  logic        score_reg, score_next;

  logic [15:0] lfsr_q;
  logic        lfsr_unused;
  logic [9:0]  x_dec;
  logic        respawn;

  lfsr16 u_lfsr (
    .clk   (clk),
    .rst_n (rst_n),
    .seed  (LFSR_SEED),
    .q     (lfsr_q)
  );

  // Only the low byte sets the spawn row; the rest of the state just whitens it.
  assign lfsr_unused = ^lfsr_q[15:8];

  assign respawn = (x_reg < SPEED);
  assign x_dec   = x_reg - SPEED;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      x_reg     <= X_START;
      y_reg     <= Y_INIT;
      score_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      x_reg     <= x_next;
      y_reg     <= y_next;
      score_reg <= score_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    x_next     = x_reg;
    y_next     = y_reg;
    score_next = 1'b0;

    case (state_reg)
      IDLE: begin
        if (start) begin
          state_next = RUN;
        end
      end

      RUN: begin
        // game_over dominates both start and a coincident frame tick.
        if (game_over) begin
          state_next = STOP;
        end else if (frame_tick) begin
          if (respawn) begin
            x_next = X_START;
            y_next = Y_MIN + {1'b0, lfsr_q[7:0]};
          end else begin
            x_next     = x_dec;
            score_next = (x_reg >= BIRD_X) && (x_dec < BIRD_X);
          end
        end
      end

      STOP: begin
        if (start && !game_over) begin
          state_next = RUN;
          x_next     = X_START;
          y_next     = Y_INIT;
        end
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign pillar_up_x   = x_reg;
  assign pillar_y      = y_reg;
  assign gap_top       = y_reg - GAP;
  assign pillar_active = (state_reg == RUN);
  assign score_pulse   = score_reg;

  // Design invariants relied on by the sprite lookup stages downstream.
  a_lfsr_nonzero : assert property (@(posedge clk) disable iff (!rst_n)
    lfsr_q != 16'd0);
  a_x_in_range : assert property (@(posedge clk) disable iff (!rst_n)
    x_reg <= X_START);
  a_score_in_run : assert property (@(posedge clk) disable iff (!rst_n)
    score_reg |-> (state_reg == RUN));
  a_gap_above_floor : assert property (@(posedge clk) disable iff (!rst_n)
    y_reg >= Y_MIN || y_reg == Y_INIT);

endmodule

// File: tb/tb_pillar_ctrl.sv
// Directed bench for pillar_ctrl: a frame-level reference model compared every
// cycle, plus hand-computed expectations at the key points of a run.
module tb_pillar_ctrl;

  logic       clk = 1'b0;
  bit         clk_en = 1'b0;
  logic       rst_n = 1'b1;
  logic       frame_tick = 1'b0;
  logic       start = 1'b0;
  logic       game_over = 1'b0;
  logic [9:0] pillar_up_x;
  logic [8:0] pillar_y;
  logic [8:0] gap_top;
  logic       pillar_active;
  logic       score_pulse;

  int errors = 0;
  int checks = 0;
  int pulses = 0;

  pillar_ctrl dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .frame_tick    (frame_tick),
    .start         (start),
    .game_over     (game_over),
    .pillar_up_x   (pillar_up_x),
    .pillar_y      (pillar_y),
    .gap_top       (gap_top),
    .pillar_active (pillar_active),
    .score_pulse   (score_pulse)
  );

  always #5 if (clk_en) clk = ~clk;

  task automatic check(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  function automatic logic [15:0] lfsr_step(input logic [15:0] v);
    return {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
  endfunction

  // Reference model: game mode 0 = waiting, 1 = running, 2 = frozen.
  int          m_mode;
  int          m_x;
  int          m_y;
  bit          m_score;
  logic [15:0] m_lfsr;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_mode  <= 0;
      m_x     <= 691;
      m_y     <= 288;
      m_score <= 1'b0;
      m_lfsr  <= 16'hACE1;
    end else begin
      m_lfsr  <= lfsr_step(m_lfsr);
      m_score <= 1'b0;
      if (m_mode == 0) begin
        if (start) m_mode <= 1;
      end else if (m_mode == 1) begin
        if (game_over) begin
          m_mode <= 2;
        end else if (frame_tick) begin
          if (m_x < 2) begin
            m_x <= 691;
            m_y <= 160 + int'(m_lfsr[7:0]);
          end else begin
            m_x     <= m_x - 2;
            m_score <= (m_x >= 200) && (m_x - 2 < 200);
          end
        end
      end else begin
        if (start && !game_over) begin
          m_mode <= 1;
          m_x    <= 691;
          m_y    <= 288;
        end
      end
    end
  end

  always @(negedge clk) begin
    check("cmp_x", int'(pillar_up_x), m_x);
    check("cmp_y", int'(pillar_y), m_y);
    check("cmp_gap_top", int'(gap_top), m_y - 120);
    check("cmp_active", int'(pillar_active), int'(m_mode == 1));
    check("cmp_score", int'(score_pulse), int'(m_score));
    if (score_pulse) pulses++;
  end

  task automatic cyc(input bit ft, input bit st, input bit go);
    frame_tick = ft;
    start      = st;
    game_over  = go;
    @(posedge clk);
    #1;
    frame_tick = 1'b0;
    start      = 1'b0;
    game_over  = 1'b0;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) cyc(1'b1, 1'b0, 1'b0);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_x"}, int'(pillar_up_x), 691);
    check({tag, "_y"}, int'(pillar_y), 288);
    check({tag, "_gap_top"}, int'(gap_top), 168);
    check({tag, "_active"}, int'(pillar_active), 0);
    check({tag, "_score"}, int'(score_pulse), 0);
  endtask

  int exp_y;

  initial begin
    // Pin the reference LFSR against hand-stepped values from the seed.
    check("lfsr_model_step1", int'(lfsr_step(16'hACE1)), 16'h59C3);
    check("lfsr_model_step2", int'(lfsr_step(lfsr_step(16'hACE1))), 16'hB387);

    #1 rst_n = 1'b0;
    #20;
    check_reset_values("reset_noclk");
    $display("reset with clock stopped: x=%0d y=%0d", pillar_up_x, pillar_y);

    clk_en = 1'b1;
    @(posedge clk);
    #1 rst_n = 1'b1;

    for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0, 1'b0);
    check("idle_ticks_x", int'(pillar_up_x), 691);
    $display("idle ticks: x=%0d active=%0d", pillar_up_x, pillar_active);

    cyc(1'b1, 1'b1, 1'b0);
    check("start_active", int'(pillar_active), 1);
    check("start_tick_ignored_x", int'(pillar_up_x), 691);
    $display("start: x=%0d active=%0d", pillar_up_x, pillar_active);

    ticks(10);
    check("motion10_x", int'(pillar_up_x), 671);
    check("motion10_y", int'(pillar_y), 288);
    $display("10 ticks: x=%0d y=%0d", pillar_up_x, pillar_y);

    ticks(235);
    check("pre_score_x", int'(pillar_up_x), 201);
    check("pre_score_pulses", pulses, 0);
    cyc(1'b1, 1'b0, 1'b0);
    check("score_x", int'(pillar_up_x), 199);
    check("score_pulse_hi", int'(score_pulse), 1);
    cyc(1'b0, 1'b0, 1'b0);
    check("score_pulse_lo", int'(score_pulse), 0);
    $display("score crossing: x=199 pulses=%0d", pulses);

    ticks(99);
    check("pre_respawn_x", int'(pillar_up_x), 1);
    exp_y = 160 + int'(m_lfsr[7:0]);
    cyc(1'b1, 1'b0, 1'b0);
    check("respawn_x", int'(pillar_up_x), 691);
    check("respawn_y", int'(pillar_y), exp_y);
    check("respawn_score", int'(score_pulse), 0);
    check("respawn_pulses", pulses, 1);
    $display("respawn: x=%0d y=%0d expected y=%0d", pillar_up_x, pillar_y, exp_y);

    ticks(2);
    cyc(1'b1, 1'b0, 1'b1);
    check("freeze_x", int'(pillar_up_x), 687);
    check("freeze_active", int'(pillar_active), 0);
    cyc(1'b1, 1'b0, 1'b0);
    check("stop_tick_x", int'(pillar_up_x), 687);
    $display("game over: x=%0d active=%0d", pillar_up_x, pillar_active);

    cyc(1'b0, 1'b1, 1'b0);
    check("restart_x", int'(pillar_up_x), 691);
    check("restart_y", int'(pillar_y), 288);
    check("restart_active", int'(pillar_active), 1);
    $display("restart: x=%0d y=%0d", pillar_up_x, pillar_y);

    cyc(1'b0, 1'b1, 1'b1);
    check("start_go_run_active", int'(pillar_active), 0);
    cyc(1'b0, 1'b1, 1'b1);
    check("start_go_stop_active", int'(pillar_active), 0);
    cyc(1'b0, 1'b1, 1'b0);
    check("rerun_active", int'(pillar_active), 1);
    $display("start+game_over: active=%0d after restart", pillar_active);

    ticks(130);
    check("pre_async_x", int'(pillar_up_x), 431);
    #2 rst_n = 1'b0;
    #1;
    check_reset_values("async_reset");
    $display("async reset at x=431: x=%0d active=%0d", pillar_up_x, pillar_active);
    @(posedge clk);
    #1 rst_n = 1'b1;
    cyc(1'b1, 1'b0, 1'b0);
    check("post_reset_idle_x", int'(pillar_up_x), 691);
    check("post_reset_idle_active", int'(pillar_active), 0);
    $display("after reset tick: x=%0d active=%0d", pillar_up_x, pillar_active);

    repeat (2) @(posedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
